// File: rtl/serial_deser.sv
// serial_deser: serial-in / parallel-out deserializer.
//
// Takes a serial bit stream, normally the registered q of an upstream D
// flip-flop. It samples one bit on each ck rise where d_en=1 and assembles
// WIDTH-bit words. Each completed word is presented on a valid/ready output.
// If a completed word has to be dropped, a sticky overrun flag is set.
//
// Ports:
//   ck        system clock, rising edge active
//   rst_n     asynchronous active-low reset
//   d         serial data bit
//   d_en      bit qualifier; d is sampled only when d_en=1
//   clr       synchronous frame restart; zeroes the shift register,
//             bit_cnt and overrun; leaves data_out and valid untouched
//   ready     downstream accepts data_out this cycle
//   data_out  last completed word
//   valid     data_out holds an unconsumed word; this is the FSM state
//             (1 = FULL, 0 = EMPTY)
//   overrun   sticky: a completed word was dropped
//   bit_cnt   bits received so far in the current word
//
// Handshake: a word transfers on a ck rise where valid=1 and ready=1.
// While valid=1, data_out is stable until that transfer happens. The one
// exception is a transfer that coincides with a completion: data_out then
// moves straight to the new word and valid stays 1. ready is ignored when
// valid=0.
module serial_deser #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     ck,
  input  logic                     rst_n,
  input  logic                     d,
  input  logic                     d_en,
  input  logic                     clr,
  input  logic                     ready,
  output logic [WIDTH-1:0]         data_out,
  output logic                     valid,
  output logic                     overrun,
  output logic [$clog2(WIDTH)-1:0] bit_cnt
);

  localparam int            CW   = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_next;
  logic             complete;
  logic             load;
  logic             ovr_set;

  // clr takes priority over d_en, so a completion is impossible while clr=1.
  assign complete = d_en & ~clr & (bit_cnt == LAST);

  // shreg_next is the word including the bit sampled on this edge. It is
  // used both to advance the shift register and to load data_out on a
  // completion edge.
  generate
    if (MSB_FIRST) begin : g_msb
      assign shreg_next = {shreg[WIDTH-2:0], d};
    end else begin : g_lsb
      assign shreg_next = {d, shreg[WIDTH-1:1]};
    end
  endgenerate

  // Input side: shift register and bit counter.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (clr) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (d_en) begin
      shreg   <= shreg_next;
      bit_cnt <= complete ? '0 : bit_cnt + CW'(1);
    end
  end

  // Output side: EMPTY/FULL state register.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Output side: next state, word load and overrun decision.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    ovr_set    = 1'b0;
    case (state)
      EMPTY: begin
        if (complete) begin
          load       = 1'b1;
          state_next = FULL;
        end
      end
      FULL: begin
        if (complete) begin
          // The word is only replaced if the old one is consumed on this edge.
          if (ready) begin
            load = 1'b1;
          end else begin
            ovr_set = 1'b1;
          end
        end else if (ready) begin
          state_next = EMPTY;
        end
      end
      default: begin
        state_next = EMPTY;
      end
    endcase
  end

  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
    end else if (load) begin
      data_out <= shreg_next;
    end
  end

  // overrun is sticky until clr or reset. clr and ovr_set never coincide,
  // because no completion can occur while clr=1.
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (clr) begin
      overrun <= 1'b0;
    end else if (ovr_set) begin
      overrun <= 1'b1;
    end
  end

  assign valid = (state == FULL);

endmodule

// File: tb/tb_serial_deser.sv
// tb_serial_deser: bench for serial_deser.
// Two instances (MSB_FIRST=1 and MSB_FIRST=0) share the same input stimulus.
// They are compared each cycle against a word-level reference model built
// from a queue of received bits.
module tb_serial_deser;

  localparam int W  = 8;
  localparam int CW = $clog2(W);

  // clock / reset
  logic ck = 1'b0;
  logic rst_n;
  always #5 ck = ~ck;

  logic d, d_en, clr, ready;
  logic [W-1:0]  data_m, data_l;
  logic          valid_m, valid_l, ovr_m, ovr_l;
  logic [CW-1:0] cnt_m, cnt_l;

  serial_deser #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .ck(ck), .rst_n(rst_n), .d(d), .d_en(d_en), .clr(clr), .ready(ready),
    .data_out(data_m), .valid(valid_m), .overrun(ovr_m), .bit_cnt(cnt_m)
  );

  serial_deser #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .ck(ck), .rst_n(rst_n), .d(d), .d_en(d_en), .clr(clr), .ready(ready),
    .data_out(data_l), .valid(valid_l), .overrun(ovr_l), .bit_cnt(cnt_l)
  );

  // reference model state
  logic         cur_bits[$];
  logic         m_valid;
  logic         m_ovr;
  logic [W-1:0] m_data_m;
  logic [W-1:0] m_data_l;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cur_bits.delete();
    m_valid  = 1'b0;
    m_ovr    = 1'b0;
    m_data_m = '0;
    m_data_l = '0;
  endtask

  // One ck rise of the model, from the inputs that were sampled on it.
  task automatic model_edge(input logic b, input logic en, input logic c, input logic r);
    logic         done;
    logic [W-1:0] wm, wl;
    done = 1'b0;
    wm   = '0;
    wl   = '0;
    if (c) begin
      cur_bits.delete();
      m_ovr = 1'b0;
    end else if (en) begin
      cur_bits.push_back(b);
      if (cur_bits.size() == W) begin
        done = 1'b1;
        for (int i = 0; i < W; i++) begin
          wm[W-1-i] = cur_bits[i];
          wl[i]     = cur_bits[i];
        end
        cur_bits.delete();
      end
    end
    if (done) begin
      if (!m_valid || r) begin
        m_data_m = wm;
        m_data_l = wl;
        m_valid  = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_valid && r) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".data_m"},  32'(data_m),  32'(m_data_m));
    chk({tag, ".data_l"},  32'(data_l),  32'(m_data_l));
    chk({tag, ".valid_m"}, 32'(valid_m), 32'(m_valid));
    chk({tag, ".valid_l"}, 32'(valid_l), 32'(m_valid));
    chk({tag, ".ovr_m"},   32'(ovr_m),   32'(m_ovr));
    chk({tag, ".ovr_l"},   32'(ovr_l),   32'(m_ovr));
    chk({tag, ".cnt_m"},   32'(cnt_m),   32'(cur_bits.size()));
    chk({tag, ".cnt_l"},   32'(cnt_l),   32'(cur_bits.size()));
  endtask

  // driver: inputs change 1 time unit after the rising edge, outputs are
  // sampled 1 time unit after the next rising edge
  task automatic step(input string tag, input logic b, input logic en,
                      input logic c, input logic r);
    d = b; d_en = en; clr = c; ready = r;
    @(posedge ck);
    model_edge(b, en, c, r);
    #1;
    check_all(tag);
  endtask

  // send a byte with d_en held high, first bit = w[7]
  task automatic send_byte(input string tag, input logic [7:0] w, input logic r);
    for (int i = 7; i >= 0; i--) step(tag, w[i], 1'b1, 1'b0, r);
  endtask

  // assert rst_n midway between edges and check before the next edge
  task automatic async_reset(input string tag);
    d = 1'b0; d_en = 1'b0; clr = 1'b0; ready = 1'b0;
    #4;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all({tag, ".mid"});
    chk({tag, ".zero_m"}, 32'(data_m), 32'h0);
    @(posedge ck);
    #1;
    check_all({tag, ".held"});
    rst_n = 1'b1;
  endtask

  initial begin
    d = 1'b0; d_en = 1'b0; clr = 1'b0; ready = 1'b0;
    rst_n = 1'b0;
    model_reset();
    @(posedge ck);
    #1;
    check_all("por");
    rst_n = 1'b1;

    // async reset with a partial word in flight
    step("pre", 1'b1, 1'b1, 1'b0, 1'b1);
    step("pre", 1'b0, 1'b1, 1'b0, 1'b1);
    step("pre", 1'b1, 1'b1, 1'b0, 1'b1);
    chk("pre.cnt3", 32'(cnt_m), 32'd3);
    async_reset("arst");
    send_byte("b2", 8'hB2, 1'b1);
    chk("b2.const_m", 32'(data_m), 32'hB2);
    chk("b2.const_l", 32'(data_l), 32'h4D);
    chk("b2.valid", 32'(valid_m), 32'd1);
    chk("b2.cnt0", 32'(cnt_m), 32'd0);
    step("b2.after", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("b2.one_cycle", 32'(valid_m), 32'd0);

    // gapped input: 2 idle cycles after bits 3 and 6
    begin
      logic [7:0] w;
      w = 8'hB2;
      for (int i = 7; i >= 0; i--) begin
        step("gap", w[i], 1'b1, 1'b0, 1'b1);
        if (i == 5 || i == 2) begin
          step("gap.idle", 1'b1, 1'b0, 1'b0, 1'b1);
          step("gap.idle", 1'b0, 1'b0, 1'b0, 1'b1);
        end
      end
      chk("gap.const", 32'(data_m), 32'hB2);
      step("gap.after", 1'b0, 1'b0, 1'b0, 1'b1);
    end

    // back-pressure and overrun
    send_byte("bp1", 8'hB2, 1'b0);
    send_byte("bp2", 8'h4D, 1'b0);
    chk("bp.hold", 32'(data_m), 32'hB2);
    chk("bp.ovr", 32'(ovr_m), 32'd1);
    step("bp.accept", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("bp.drain", 32'(valid_m), 32'd0);
    chk("bp.sticky", 32'(ovr_m), 32'd1);
    step("bp.clr", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("bp.cleared", 32'(ovr_m), 32'd0);

    // simultaneous accept and completion
    send_byte("a5", 8'hA5, 1'b0);
    begin
      logic [7:0] w;
      w = 8'h3C;
      for (int i = 7; i >= 0; i--) step("3c", w[i], 1'b1, 1'b0, (i == 0));
    end
    chk("3c.const", 32'(data_m), 32'h3C);
    chk("3c.valid", 32'(valid_m), 32'd1);
    chk("3c.ovr", 32'(ovr_m), 32'd0);
    step("3c.after", 1'b0, 1'b0, 1'b0, 1'b1);

    // clr mid-word with a coincident qualified bit
    for (int i = 0; i < 3; i++) step("cm.pre", 1'b1, 1'b1, 1'b0, 1'b1);
    step("cm.clr", 1'b1, 1'b1, 1'b1, 1'b1);
    chk("cm.cnt0", 32'(cnt_m), 32'd0);
    send_byte("cm.0f", 8'h0F, 1'b1);
    chk("cm.const", 32'(data_m), 32'h0F);

    // randomized traffic
    for (int n = 0; n < 800; n++) begin
      step("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 40) == 0), 1'($urandom_range(0, 2) != 0));
      if (n == 400) async_reset("rnd.arst");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
